pcie_tl_switch: RTL and testbench



---
 rtl/pcie_tl_pkg.sv | 18 +
 rtl/tl_fifo.sv | 72 +++++++
 rtl/pcie_tl_switch.sv | 145 ++++++++++++++
 tb/tb_pcie_tl_switch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the transaction-layer switch: FSM encoding and routing helper.
package pcie_tl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 4'd0,
    ST_INIT   = 4'd1,
    ST_IDLE   = 4'd2,
    ST_ACTIVE = 4'd3
  } state_t;

  // Destination channel carried in the top dw bits of a data_w-bit word.
  function automatic logic [63:0] dest_of(input logic [63:0] word, input int data_w, input int dw);
    return (word >> (data_w - dw)) & ((64'd1 << dw) - 64'd1);
  endfunction

endpackage

// File: rtl/tl_fifo.sv
// Circular FIFO with threshold flags and a sticky overflow flag.
// FWFT=1 exposes the head combinationally; FWFT=0 registers the popped word.
module tl_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter bit FWFT   = 1'b1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic [AW:0]       thr_hi,
  input  logic [AW:0]       thr_lo,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              empty_next,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count, count_nxt;
  logic              pop_ok, push_ok;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop_ok       = pop && (count != '0);
  assign push_ok      = push && ((count != FULL_CNT) || pop_ok);
  assign count_nxt    = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= thr_hi);
  assign almost_empty = (count <= thr_lo);
  assign empty_next   = (count_nxt == '0);

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = mem[rd_ptr];
  end else begin : g_reg
    // Registered read: the head moves to dout only on a successful pop.
    always_ff @(posedge clk) begin
      if (!reset)      dout <= '0;
      else if (pop_ok) dout <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/pcie_tl_switch.sv
// NCH-port switch: input FIFOs, round-robin arbiter routing by destination field,
// output FIFOs with registered reads, and per-output popped-word counters.
module pcie_tl_switch
  import pcie_tl_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5,
  localparam int DW    = $clog2(NCH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [AW:0]           umbral_alto,
  input  logic [AW:0]           umbral_bajo,
  input  logic [NCH-1:0]        push_in,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH-1:0]        pop_out,
  output logic [NCH*DATA_W-1:0] data_out,
  output logic [NCH-1:0]        out_empty,
  output logic [NCH-1:0]        out_almost_empty,
  output logic [NCH-1:0]        in_almost_full,
  output logic [NCH-1:0]        error,
  input  logic                  req,
  input  logic [DW-1:0]         idx,
  output logic [CNT_W-1:0]      contador,
  output logic                  valid,
  output logic [STATE_W-1:0]    state
);

  state_t            st;
  logic [AW:0]       alto, bajo;
  logic [DATA_W-1:0] in_head [NCH];
  logic [DW-1:0]     in_dest [NCH];
  logic [NCH-1:0]    in_empty, in_empty_nxt, in_push, in_pop, in_full, in_aempty;
  logic [NCH-1:0]    out_push, out_afull, out_full, out_empty_nxt, out_ovf;
  logic [NCH-1:0]    cand;
  logic [DATA_W-1:0] out_din;
  logic [DW-1:0]     last_grant, grant_idx, cand_idx;
  logic              grant_valid, xfer;
  logic [CNT_W-1:0]  word_cnt [NCH];
  logic              unused_sigs;

  assign state       = st;
  assign xfer        = grant_valid && (st == ST_ACTIVE);
  assign out_din     = in_head[grant_idx];
  assign unused_sigs = ^{in_full, in_aempty, out_empty_nxt, out_ovf};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign in_push[i]  = push_in[i] && (st != ST_RESET);
    assign in_pop[i]   = xfer && (grant_idx == DW'(i));
    assign in_dest[i]  = DW'(dest_of(64'(in_head[i]), DATA_W, DW));
    assign cand[i]     = !in_empty[i] && !out_afull[in_dest[i]] && !out_full[in_dest[i]];
    assign out_push[i] = xfer && (in_dest[grant_idx] == DW'(i));

    tl_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1'b1)) u_in (
      .clk(clk), .reset(reset), .push(in_push[i]), .pop(in_pop[i]),
      .din(data_in[i*DATA_W +: DATA_W]), .thr_hi(alto), .thr_lo(bajo),
      .dout(in_head[i]), .empty(in_empty[i]), .full(in_full[i]),
      .almost_full(in_almost_full[i]), .almost_empty(in_aempty[i]),
      .empty_next(in_empty_nxt[i]), .overflow(error[i])
    );

    tl_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1'b0)) u_out (
      .clk(clk), .reset(reset), .push(out_push[i]), .pop(pop_out[i]),
      .din(out_din), .thr_hi(alto), .thr_lo(bajo),
      .dout(data_out[i*DATA_W +: DATA_W]), .empty(out_empty[i]), .full(out_full[i]),
      .almost_full(out_afull[i]), .almost_empty(out_almost_empty[i]),
      .empty_next(out_empty_nxt[i]), .overflow(out_ovf[i])
    );
  end

  // Round-robin search starting after the last granted channel; the last one checked is last_grant itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand_idx = last_grant + DW'(k);
      if (!grant_valid && cand[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Control FSM; init always wins over the idle/active transitions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= ST_RESET;
    end else begin
      case (st)
        ST_RESET:  st <= ST_INIT;
        ST_INIT:   if (!init) st <= ST_IDLE;
        ST_IDLE:   if (init) st <= ST_INIT;
                   else if (!(&in_empty)) st <= ST_ACTIVE;
        ST_ACTIVE: if (init) st <= ST_INIT;
                   else if (&in_empty_nxt) st <= ST_IDLE;
        default:   st <= ST_RESET;
      endcase
    end
  end

  // Thresholds follow the inputs for as long as the FSM sits in INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alto <= (AW+1)'(DEPTH-1);
      bajo <= (AW+1)'(1);
    end else if (st == ST_INIT) begin
      alto <= umbral_alto;
      bajo <= umbral_bajo;
    end
  end

  // Remember the winner so the next search starts just past it.
  always_ff @(posedge clk) begin
    if (!reset)    last_grant <= DW'(NCH-1);
    else if (xfer) last_grant <= grant_idx;
  end

  // Count words actually delivered on each output; pops on an empty FIFO do not count.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NCH; j++) begin
      if (!reset)                          word_cnt[j] <= '0;
      else if (pop_out[j] && !out_empty[j]) word_cnt[j] <= word_cnt[j] + 1'b1;
    end
  end

  // Counter readback is only honoured while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      contador <= '0;
    end else if (req && (st == ST_IDLE)) begin
      valid    <= 1'b1;
      contador <= word_cnt[idx];
    end else begin
      valid    <= 1'b0;
      contador <= '0;
    end
  end

endmodule

// File: tb/tb_pcie_tl_switch.sv
// Scoreboard bench for pcie_tl_switch: per-flow expected queues filled at push time,
// drained by an independent output monitor; directed scenarios plus a random phase.
module tb_pcie_tl_switch;

  localparam int NCH = 4, DATA_W = 10, DEPTH = 8, CNT_W = 5, DW = 2, AW = 3;

  logic                  clk = 1'b0;
  logic                  reset, init, req;
  logic [AW:0]           umbral_alto, umbral_bajo;
  logic [NCH-1:0]        push_in, pop_out;
  logic [NCH*DATA_W-1:0] data_in;
  logic [NCH*DATA_W-1:0] data_out;
  logic [NCH-1:0]        out_empty, out_almost_empty, in_almost_full, error;
  logic [DW-1:0]         idx;
  logic [CNT_W-1:0]      contador;
  logic                  valid;
  logic [3:0]            state;

  pcie_tl_switch #(.NCH(NCH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push_in(push_in), .data_in(data_in), .pop_out(pop_out), .data_out(data_out),
    .out_empty(out_empty), .out_almost_empty(out_almost_empty), .in_almost_full(in_almost_full),
    .error(error), .req(req), .idx(idx), .contador(contador), .valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  // Expected words per (source, destination) flow, and every word seen per output.
  logic [DATA_W-1:0]     exp_q  [NCH*NCH][$];
  logic [DATA_W-1:0]     seen_q [NCH][$];
  int                    outstanding [NCH];
  int                    seq [NCH];
  int                    n_checks = 0;
  int                    n_fail = 0;
  logic [NCH-1:0]        mon_fired;
  logic [DATA_W-1:0]     mon_w, mon_exp;
  int                    mon_src, mon_q;
  logic [NCH-1:0]        rnd_push;
  logic [NCH*DATA_W-1:0] rnd_data;
  logic [DATA_W-1:0]     last_w;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_word(input int dest, input int src, input int sq);
    logic [1:0] d = 2'(dest);
    logic [1:0] s = 2'(src);
    logic [5:0] q = 6'(sq);
    return {d, s, q};
  endfunction

  function automatic int total_outstanding();
    int t = 0;
    for (int q = 0; q < NCH*NCH; q++) t += exp_q[q].size();
    return t;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one cycle; every accepted push is recorded in the flow queue named by its own header.
  task automatic applyStimulus(input logic [NCH-1:0] push, input logic [NCH*DATA_W-1:0] data,
                               input logic [NCH-1:0] pop, input logic [NCH-1:0] drop);
    logic [DATA_W-1:0] w;
    int s;
    push_in = push;
    data_in = data;
    pop_out = pop;
    for (int i = 0; i < NCH; i++) begin
      if (push[i] && !drop[i]) begin
        w = data[i*DATA_W +: DATA_W];
        s = int'(w[DATA_W-DW-1 -: DW]);
        exp_q[s*NCH + int'(w[DATA_W-1 -: DW])].push_back(w);
        outstanding[s]++;
      end
    end
    tick(1);
  endtask

  task automatic clearSb();
    for (int q = 0; q < NCH*NCH; q++) exp_q[q].delete();
    for (int i = 0; i < NCH; i++) begin
      seen_q[i].delete();
      outstanding[i] = 0;
      seq[i] = 0;
    end
  endtask

  task automatic doReset();
    reset = 1'b0; init = 1'b0; req = 1'b0; idx = '0;
    push_in = '0; pop_out = '0; data_in = '0;
    umbral_alto = 4'd7; umbral_bajo = 4'd1;
    tick(2);
    clearSb();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_data_out", 32'(data_out == '0), 32'd1);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_contador", 32'(contador), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_out_empty", 32'(out_empty), 32'hF);
  endtask

  task automatic startInit(input int alto, input int bajo);
    reset = 1'b1; init = 1'b1; push_in = '0; pop_out = '0;
    umbral_alto = 4'(alto); umbral_bajo = 4'(bajo);
    tick(1);
    checkOutput("init_state", 32'(state), 32'd1);
  endtask

  task automatic endInit();
    init = 1'b0; push_in = '0; pop_out = '0;
    tick(1);
    checkOutput("idle_state", 32'(state), 32'd2);
  endtask

  task automatic drain();
    push_in = '0;
    pop_out = '1;
    for (int k = 0; k < 400; k++) begin
      if (total_outstanding() == 0) break;
      tick(1);
    end
    pop_out = '0;
    tick(2);
    checkOutput("drain_left", 32'(total_outstanding()), 32'd0);
  endtask

  // Output monitor: a pop on a non-empty output must yield the oldest pending word of its flow.
  always @(posedge clk) begin
    mon_fired = reset ? (pop_out & ~out_empty) : '0;
    #1;
    for (int j = 0; j < NCH; j++) begin
      if (mon_fired[j]) begin
        mon_w   = data_out[j*DATA_W +: DATA_W];
        mon_src = int'(mon_w[DATA_W-DW-1 -: DW]);
        mon_q   = mon_src*NCH + j;
        seen_q[j].push_back(mon_w);
        checkOutput("route_dest", 32'(mon_w[DATA_W-1 -: DW]), 32'(j));
        checkOutput("sb_pending", 32'(exp_q[mon_q].size() > 0), 32'd1);
        if (exp_q[mon_q].size() > 0) begin
          mon_exp = exp_q[mon_q].pop_front();
          checkOutput("sb_data", 32'(mon_w), 32'(mon_exp));
          outstanding[mon_src]--;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, init handshake and a single routed word.
    doReset();
    startInit(6, 1);
    endInit();
    applyStimulus(4'b0001, {30'd0, 10'h205}, 4'b0000, 4'b0000);
    applyStimulus('0, '0, '0, '0);
    checkOutput("single_active", 32'(state), 32'd3);
    applyStimulus('0, '0, '0, '0);
    checkOutput("single_back_idle", 32'(state), 32'd2);
    checkOutput("single_out2_nonempty", 32'(out_empty[2]), 32'd0);
    applyStimulus('0, '0, 4'b0100, '0);
    checkOutput("single_data", 32'(data_out[2*DATA_W +: DATA_W]), 32'h205);
    checkOutput("single_out2_empty", 32'(out_empty[2]), 32'd1);
    pop_out = '0;

    // Round-robin: two words per input, all for output 0, loaded while held in INIT.
    doReset();
    startInit(8, 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) rnd_data[i*DATA_W +: DATA_W] = mk_word(0, i, k);
      applyStimulus(4'hF, rnd_data, '0, '0);
    end
    checkOutput("rr_held_init", 32'(state), 32'd1);
    endInit();
    seen_q[0].delete();
    for (int c = 0; c < 20; c++) applyStimulus('0, '0, 4'b0001, '0);
    checkOutput("rr_count", 32'(seen_q[0].size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < seen_q[0].size())
        checkOutput("rr_order", 32'(seen_q[0][k][DATA_W-DW-1 -: DW]), 32'(k % NCH));
    end
    drain();

    // Backpressure: output almost-full threshold of 3 stalls the rest in the input.
    doReset();
    startInit(3, 2);
    endInit();
    for (int k = 0; k < 6; k++) applyStimulus(4'b0001, {30'd0, mk_word(1, 0, k)}, '0, '0);
    applyStimulus('0, '0, '0, '0);
    tick(9);
    checkOutput("bp_state_active", 32'(state), 32'd3);
    checkOutput("bp_in0_three_left", 32'(in_almost_full[0]), 32'd1);
    checkOutput("bp_out1_three_in", 32'(out_almost_empty[1]), 32'd0);
    applyStimulus('0, '0, 4'b0010, '0);
    applyStimulus('0, '0, '0, '0);
    tick(4);
    checkOutput("bp_in0_two_left", 32'(in_almost_full[0]), 32'd0);
    checkOutput("bp_out1_refilled", 32'(out_almost_empty[1]), 32'd0);
    drain();

    // Overflow: nine pushes into a depth-8 input with arbitration held off.
    doReset();
    startInit(6, 1);
    for (int k = 0; k < 9; k++)
      applyStimulus(4'b0010, {20'd0, mk_word(3, 1, k), 10'd0}, '0, (k == 8) ? 4'b0010 : 4'b0000);
    push_in = '0;
    tick(1);
    checkOutput("ovf_error", 32'(error), 32'h2);
    checkOutput("ovf_in1_afull", 32'(in_almost_full[1]), 32'd1);
    endInit();
    seen_q[3].delete();
    drain();
    checkOutput("ovf_emerged", 32'(seen_q[3].size()), 32'd8);
    checkOutput("ovf_sticky", 32'(error), 32'h2);

    // Word counter: five real pops then two on an empty output.
    doReset();
    startInit(6, 1);
    endInit();
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, {10'd0, mk_word(3, 2, k), 20'd0}, '0, '0);
    applyStimulus('0, '0, '0, '0);
    tick(7);
    for (int k = 0; k < 7; k++) applyStimulus('0, '0, 4'b1000, '0);
    applyStimulus('0, '0, '0, '0);
    tick(1);
    last_w = mk_word(3, 2, 4);
    checkOutput("cnt_idle", 32'(state), 32'd2);
    checkOutput("cnt_data_held", 32'(data_out[3*DATA_W +: DATA_W]), 32'(last_w));
    req = 1'b1; idx = 2'd3;
    tick(1);
    checkOutput("cnt_valid", 32'(valid), 32'd1);
    checkOutput("cnt_value3", 32'(contador), 32'd5);
    idx = 2'd0;
    tick(1);
    checkOutput("cnt_value0", 32'(contador), 32'd0);
    req = 1'b0;
    tick(1);
    checkOutput("cnt_valid_drop", 32'(valid), 32'd0);

    // Zero almost-full threshold: everything stalls, and req in ACTIVE reads nothing.
    init = 1'b1; umbral_alto = 4'd0; umbral_bajo = 4'd1;
    tick(1);
    checkOutput("z_init", 32'(state), 32'd1);
    endInit();
    applyStimulus(4'b0001, {30'd0, mk_word(1, 0, 0)}, '0, '0);
    applyStimulus('0, '0, '0, '0);
    tick(4);
    checkOutput("z_active", 32'(state), 32'd3);
    checkOutput("z_no_transfer", 32'(out_empty), 32'hF);
    checkOutput("z_in_afull", 32'(in_almost_full), 32'hF);
    req = 1'b1; idx = 2'd3;
    tick(1);
    checkOutput("z_req_valid", 32'(valid), 32'd0);
    checkOutput("z_req_contador", 32'(contador), 32'd0);
    req = 1'b0;

    // Mid-operation reset discards the stalled word.
    doReset();
    startInit(7, 1);
    endInit();
    tick(3);
    checkOutput("discard_idle", 32'(state), 32'd2);
    checkOutput("discard_empty", 32'(out_empty), 32'hF);

    // Random traffic with random thresholds; pushes limited so no input can overflow.
    doReset();
    startInit($urandom_range(2, 8), $urandom_range(0, 3));
    endInit();
    for (int c = 0; c < 800; c++) begin
      rnd_push = '0;
      rnd_data = '0;
      for (int i = 0; i < NCH; i++) begin
        if (($urandom_range(0, 1) == 1) && (outstanding[i] < DEPTH)) begin
          rnd_push[i] = 1'b1;
          rnd_data[i*DATA_W +: DATA_W] = mk_word($urandom_range(0, NCH-1), i, seq[i]);
          seq[i] = (seq[i] + 1) % 64;
        end
      end
      applyStimulus(rnd_push, rnd_data, 4'($urandom_range(0, 15)), '0);
    end
    drain();
    checkOutput("rnd_no_error", 32'(error), 32'd0);
    checkOutput("rnd_idle", 32'(state), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
